adpcm_main_mul_pipe_sat: RTL and testbench
==========================================

Name: adpcm_main_mul_pipe_sat

Overview:
Parametrised pipelined multiplier with valid tracking. It is the next generation of the fixed-width, fixed-latency multiply cores used in the ADPCM datapath (quantiser and predictor coefficient products). Adds configurable operand widths, per-operand signedness, configurable pipeline depth, round-half-up right shift, optional saturation with an overflow flag, and valid propagation under clock-enable stall. Drop-in for any `mul_*` core in adpcm_main once the extra ports are tied off.

Parameters:
DIN0_WIDTH, 32, width of din0.
DIN1_WIDTH, 15, width of din1.
DOUT_WIDTH, 46, width of dout.
NUM_STAGE, 2, register stages from input to dout; legal 1..8.
DIN0_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned (zero-extended).
DIN1_SIGNED, 0, same meaning for din1.
SHIFT, 0, right shift applied to the product with round-half-up; legal 0..P-1.
SAT_EN, 0, 1 = clamp to DOUT_WIDTH range, 0 = wrap (keep LSBs).

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  synchronous, active-low reset.
ce  in  1  clock enable; 0 freezes every pipeline register, including valid.
in_valid  in  1  din0/din1 qualify this cycle (sampled only when ce=1).
din0  in  DIN0_WIDTH  operand 0.
din1  in  DIN1_WIDTH  operand 1.
out_valid  out  1  dout/ovf hold a result.
dout  out  DOUT_WIDTH  registered result.
ovf  out  1  result did not fit in DOUT_WIDTH (valid with out_valid).

Behaviour:
- Reset: sampled at posedge when reset=0. Reset has priority over ce. Clears all valid bits, dout=0, ovf=0. In-flight operands are discarded and no out_valid is ever produced for them. First capture is on the first edge with reset=1 and ce=1.
- Arithmetic:
  - Each operand is extended by 1 bit (sign or zero, per its *_SIGNED).
  - Signed product width P = DIN0_WIDTH+DIN1_WIDTH+1.
  - If SHIFT>0: r = (p + 2^(SHIFT-1)) >>> SHIFT (arithmetic). This rounds half toward +inf. SHIFT=0 gives r = p.
- Output range: signed [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] if either operand is signed. Otherwise unsigned [0, 2^DOUT_WIDTH-1].
- ovf=1 iff r is outside the output range.
  - SAT_EN=1: dout is clamped to the nearest limit.
  - SAT_EN=0: dout = r[DOUT_WIDTH-1:0].
  - If DOUT_WIDTH >= P-SHIFT, ovf is constant 0.
- Latency: exactly NUM_STAGE ce=1 edges from input capture to dout/out_valid. With ce held high, in_valid at edge k gives out_valid at edge k+NUM_STAGE.
- Throughput: one operation per ce=1 cycle, no bubbles.
- Pipelining:
  - Stage 1 registers the operands (NUM_STAGE=1: the final result directly).
  - Multiply, round and saturate may be retimed across stages 2..NUM_STAGE.
  - The final stage is always a register; no combinational input-to-output path.
- Stall: while ce=0, dout, ovf and out_valid hold their values, and din/in_valid are ignored.
- Bubbles: in_valid=0 with ce=1 shifts a 0 into the valid chain. Data registers may load don't-care values. dout is undefined while out_valid=0, except after reset (0).
- out_valid has no backpressure; the consumer uses ce to stall.

Decomposition:
- Package adpcm_mul_pkg:
  - Width helper: product width P from the two operand widths.
  - Clamp-limit functions: signed/unsigned min/max for a given width.
  - Legal NUM_STAGE bounds.
- Sub-module adpcm_main_mul_delay_line(WIDTH, DEPTH): ce-gated shift register with an active-low synchronous clear on selected bits. Used for the valid chain and for trailing data delay stages.

Test Plan:
1. Defaults; din0=32'hFFFFFFFD (-3), din1=15'h7FFF, in_valid=1, ce=1 -> 2 edges later out_valid=1, dout=-98301 (46'h3FFFFFFE8003), ovf=0.
2. SHIFT=4; products 24 and -24 on back-to-back cycles -> dout=2 then -1; also product 8 -> 1 (half rounds up).
3. DOUT_WIDTH=16, DIN0_SIGNED=1, DIN1_SIGNED=1:
   - 1000*1000 with SAT_EN=1 -> dout=32767, ovf=1.
   - -1000*1000 with SAT_EN=1 -> dout=-32768, ovf=1.
   - SAT_EN=0 -> dout=16'h4240, ovf=1.
4. NUM_STAGE=4; stream 6 ops, ce low for 3 cycles after op 2 -> results in order, out_valid and dout frozen during the stall, total latency 4 ce-cycles each.
5. in_valid pulse, then reset=0 one cycle later (NUM_STAGE=3) -> out_valid stays 0, dout=0, ovf=0. An op issued the edge after reset release emerges 3 edges later.
6. Random sweep of all signedness combinations × NUM_STAGE {1,2,8} against a reference model -> bit-exact dout/ovf, and the out_valid count equals the in_valid count.

Source files
------------

// File: rtl/adpcm_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_mul_pkg
// Purpose  : Shared helpers for the ADPCM pipelined multiplier family:
//            product-width helper, clamp-limit functions and the legal
//            pipeline-depth bounds.
// Contents : LIM_W           - width of the clamp-limit values (max DOUT 254)
//            NUM_STAGE_MIN/MAX - legal pipeline depth bounds
//            prod_width()    - signed product width of two extended operands
//            smax/smin/umax/umin() - range limits for a given output width
// Revision : 1.0 - initial release
// ============================================================================
package adpcm_mul_pkg;

  localparam int LIM_W         = 256;
  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 8;

  typedef logic signed [LIM_W-1:0] lim_t;

  // Each operand gains one extension bit; the signed product of a
  // (w0+1)-bit and a (w1+1)-bit value always fits in w0+w1+1 bits.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic lim_t smax(input int w);
    lim_t one;
    one = lim_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic lim_t smin(input int w);
    lim_t one;
    one = lim_t'(1);
    return -(one <<< (w - 1));
  endfunction

  function automatic lim_t umax(input int w);
    lim_t one;
    one = lim_t'(1);
    return (one <<< w) - one;
  endfunction

  function automatic lim_t umin(input int w);
    return lim_t'(0);
  endfunction

endpackage : adpcm_mul_pkg
`default_nettype wire

// File: rtl/adpcm_main_mul_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_main_mul_delay_line
// Purpose  : Clock-enable gated shift register. Bits selected by CLR_MASK are
//            synchronously cleared while reset is low; unselected bits hold.
//            Reset takes priority over ce.
// Ports    : clk   - clock, rising edge
//            reset - synchronous active-low clear of CLR_MASK bits
//            ce    - shift enable; 0 freezes every stage
//            din   - word entering stage 0
//            dout  - word leaving the last stage (DEPTH cycles later)
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_main_mul_delay_line #(
  parameter int               WIDTH    = 1,
  parameter int               DEPTH    = 1,
  parameter logic [WIDTH-1:0] CLR_MASK = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i] & ~CLR_MASK;
      end
    end else if (ce) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule : adpcm_main_mul_delay_line
`default_nettype wire

// File: rtl/adpcm_main_mul_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_main_mul_pipe_sat
// Purpose  : Parametrised pipelined multiplier with valid tracking, per-operand
//            signedness, round-half-up right shift and optional saturation.
//            Pipeline: [operand regs] -> multiply/round/range -> result reg
//            -> trailing delay stages. NUM_STAGE=1 registers the result
//            straight from the inputs.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous active-low reset (priority over ce)
//            ce        - clock enable; 0 freezes all pipeline state
//            in_valid  - din0/din1 qualify this cycle
//            din0      - operand 0 (DIN0_WIDTH)
//            din1      - operand 1 (DIN1_WIDTH)
//            out_valid - dout/ovf hold a result
//            dout      - registered result (DOUT_WIDTH)
//            ovf       - rounded product did not fit the output range
// Notes    : NUM_STAGE outside 1..8 is clamped into that range.
//            DOUT_WIDTH must stay below adpcm_mul_pkg::LIM_W-1.
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_main_mul_pipe_sat
  import adpcm_mul_pkg::*;
#(
  parameter int DIN0_WIDTH  = 32,
  parameter int DIN1_WIDTH  = 15,
  parameter int DOUT_WIDTH  = 46,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SAT_EN      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int STAGES = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                          (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
  localparam int P      = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  // Working width: room for the product, the rounding carry and the output
  // limits, plus guard bits so every compare is a plain signed compare.
  localparam int CW     = ((P + 1 > DOUT_WIDTH) ? P + 1 : DOUT_WIDTH) + 2;
  localparam int TAIL   = (STAGES > 2) ? STAGES - 2 : 0;

  localparam bit OUT_SIGNED   = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam bit OVF_POSSIBLE = DOUT_WIDTH < (P - SHIFT);

  localparam logic signed [CW-1:0] HI = OUT_SIGNED ? CW'(smax(DOUT_WIDTH))
                                                   : CW'(umax(DOUT_WIDTH));
  localparam logic signed [CW-1:0] LO = OUT_SIGNED ? CW'(smin(DOUT_WIDTH))
                                                   : CW'(umin(DOUT_WIDTH));

  // Half an LSB of the shifted result; evaluates to zero when SHIFT=0.
  localparam logic [CW-1:0] RND = ({{(CW-1){1'b0}}, 1'b1} << SHIFT) >> 1;

  // --------------------------------------------------------------------------
  // Operand stage
  // --------------------------------------------------------------------------
  logic [DIN0_WIDTH-1:0] op0;
  logic [DIN1_WIDTH-1:0] op1;

  generate
    if (STAGES == 1) begin : g_op_direct
      assign op0 = din0;
      assign op1 = din1;
    end else begin : g_op_reg
      // Data only: no reset needed, the valid chain qualifies it.
      always_ff @(posedge clk) begin
        if (ce) begin
          op0 <= din0;
          op1 <= din1;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Multiply, round, range check
  // --------------------------------------------------------------------------
  logic                 sgn0;
  logic                 sgn1;
  logic signed [CW-1:0] a_x;
  logic signed [CW-1:0] b_x;
  logic signed [CW-1:0] prod;
  logic signed [CW-1:0] rsum;
  logic signed [CW-1:0] r_x;

  assign sgn0 = (DIN0_SIGNED != 0) & op0[DIN0_WIDTH-1];
  assign sgn1 = (DIN1_SIGNED != 0) & op1[DIN1_WIDTH-1];
  assign a_x  = $signed({{(CW-DIN0_WIDTH){sgn0}}, op0});
  assign b_x  = $signed({{(CW-DIN1_WIDTH){sgn1}}, op1});
  assign prod = a_x * b_x;
  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  assign rsum = prod + $signed(RND);
  assign r_x  = rsum >>> SHIFT;

  logic                  ovf_c;
  logic [DOUT_WIDTH-1:0] dout_c;

  generate
    if (OVF_POSSIBLE) begin : g_range
      logic over_hi;
      logic under_lo;

      assign over_hi  = r_x > HI;
      assign under_lo = r_x < LO;
      assign ovf_c    = over_hi | under_lo;

      if (SAT_EN != 0) begin : g_sat
        always_comb begin
          dout_c = DOUT_WIDTH'(r_x);
          if (over_hi) begin
            dout_c = DOUT_WIDTH'(HI);
          end else if (under_lo) begin
            dout_c = DOUT_WIDTH'(LO);
          end
        end
      end else begin : g_wrap
        assign dout_c = DOUT_WIDTH'(r_x);
      end
    end else begin : g_fit
      // Output is wide enough for every rounded product.
      assign ovf_c  = 1'b0;
      assign dout_c = DOUT_WIDTH'(r_x);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Result register and trailing delay stages
  // --------------------------------------------------------------------------
  logic [DOUT_WIDTH-1:0] res_q;
  logic                  res_ovf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else if (ce) begin
      res_q     <= dout_c;
      res_ovf_q <= ovf_c;
    end
  end

  generate
    if (TAIL > 0) begin : g_tail
      logic [DOUT_WIDTH:0] tail_q;

      adpcm_main_mul_delay_line #(
        .WIDTH    (DOUT_WIDTH + 1),
        .DEPTH    (TAIL),
        .CLR_MASK ('1)
      ) u_tail (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   ({res_ovf_q, res_q}),
        .dout  (tail_q)
      );

      assign ovf  = tail_q[DOUT_WIDTH];
      assign dout = tail_q[DOUT_WIDTH-1:0];
    end else begin : g_no_tail
      assign ovf  = res_ovf_q;
      assign dout = res_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Valid chain: one bit per register stage, fully cleared by reset so
  // in-flight operands never produce an out_valid.
  // --------------------------------------------------------------------------
  adpcm_main_mul_delay_line #(
    .WIDTH    (1),
    .DEPTH    (STAGES),
    .CLR_MASK (1'b1)
  ) u_valid (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .din   (in_valid),
    .dout  (out_valid)
  );

endmodule : adpcm_main_mul_pipe_sat
`default_nettype wire

// File: tb/tb_adpcm_main_mul_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpcm_main_mul_pipe_sat
// Purpose  : Directed self-checking bench for adpcm_main_mul_pipe_sat.
//            Several DUT instances cover the default configuration, rounding,
//            saturate/wrap, stall behaviour, reset flush and a sweep of all
//            signedness combinations at pipeline depths 1, 2 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpcm_main_mul_pipe_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default configuration ----------------
  logic        def_ce, def_v, def_ov, def_o;
  logic [31:0] def_a;
  logic [14:0] def_b;
  logic [45:0] def_d;

  adpcm_main_mul_pipe_sat u_def (
    .clk(clk), .reset(rst_n), .ce(def_ce), .in_valid(def_v), .din0(def_a),
    .din1(def_b), .out_valid(def_ov), .dout(def_d), .ovf(def_o));

  // ---------------- SHIFT=4 ----------------
  logic        sh_ce, sh_v, sh_ov, sh_o;
  logic [31:0] sh_a;
  logic [14:0] sh_b;
  logic [45:0] sh_d;

  adpcm_main_mul_pipe_sat #(.SHIFT(4)) u_sh (
    .clk(clk), .reset(rst_n), .ce(sh_ce), .in_valid(sh_v), .din0(sh_a),
    .din1(sh_b), .out_valid(sh_ov), .dout(sh_d), .ovf(sh_o));

  // ---------------- 16-bit output, saturate and wrap ----------------
  logic        s_ce, s_v, sat_ov, sat_o, wrp_ov, wrp_o;
  logic [31:0] s_a;
  logic [14:0] s_b;
  logic [15:0] sat_d, wrp_d;

  adpcm_main_mul_pipe_sat #(.DOUT_WIDTH(16), .DIN1_SIGNED(1), .SAT_EN(1)) u_sat (
    .clk(clk), .reset(rst_n), .ce(s_ce), .in_valid(s_v), .din0(s_a),
    .din1(s_b), .out_valid(sat_ov), .dout(sat_d), .ovf(sat_o));

  adpcm_main_mul_pipe_sat #(.DOUT_WIDTH(16), .DIN1_SIGNED(1), .SAT_EN(0)) u_wrp (
    .clk(clk), .reset(rst_n), .ce(s_ce), .in_valid(s_v), .din0(s_a),
    .din1(s_b), .out_valid(wrp_ov), .dout(wrp_d), .ovf(wrp_o));

  // ---------------- NUM_STAGE=4 stall ----------------
  logic        p4_ce, p4_v, p4_ov, p4_o;
  logic [31:0] p4_a;
  logic [14:0] p4_b;
  logic [45:0] p4_d;

  adpcm_main_mul_pipe_sat #(.NUM_STAGE(4)) u_p4 (
    .clk(clk), .reset(rst_n), .ce(p4_ce), .in_valid(p4_v), .din0(p4_a),
    .din1(p4_b), .out_valid(p4_ov), .dout(p4_d), .ovf(p4_o));

  // ---------------- NUM_STAGE=3 reset flush ----------------
  logic        p3_rst, p3_ce, p3_v, p3_ov, p3_o;
  logic [31:0] p3_a;
  logic [14:0] p3_b;
  logic [45:0] p3_d;

  adpcm_main_mul_pipe_sat #(.NUM_STAGE(3)) u_p3 (
    .clk(clk), .reset(p3_rst), .ce(p3_ce), .in_valid(p3_v), .din0(p3_a),
    .din1(p3_b), .out_valid(p3_ov), .dout(p3_d), .ovf(p3_o));

  // ---------------- sweep: 4 signedness combos x depth {1,2,8} ----------------
  localparam int NSW = 12;
  localparam int NT  = 48;
  logic       sw_v;
  logic [7:0] sw_a;
  logic [5:0] sw_b;
  logic       sw_ov [NSW];
  logic       sw_o  [NSW];
  logic [9:0] sw_d  [NSW];

  generate
    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
      localparam int NS = (gi < 4) ? 1 : (gi < 8) ? 2 : 8;
      adpcm_main_mul_pipe_sat #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(6), .DOUT_WIDTH(10), .NUM_STAGE(NS),
        .DIN0_SIGNED(gi % 2), .DIN1_SIGNED((gi / 2) % 2), .SHIFT(2), .SAT_EN(1)
      ) u_dut (
        .clk(clk), .reset(rst_n), .ce(1'b1), .in_valid(sw_v), .din0(sw_a),
        .din1(sw_b), .out_valid(sw_ov[gi]), .dout(sw_d[gi]), .ovf(sw_o[gi]));
    end
  endgenerate

  // Integer reference: extend, multiply, add 2, shift right 2, clamp.
  function automatic void model(input int idx, input logic [7:0] a, input logic [5:0] b,
                                output logic [9:0] d, output logic o);
    longint ea, eb, r, hi, lo, c;
    bit     s0, s1;
    s0 = (idx % 2) != 0;
    s1 = ((idx / 2) % 2) != 0;
    ea = s0 ? longint'($signed(a)) : longint'(a);
    eb = s1 ? longint'($signed(b)) : longint'(b);
    r  = (ea * eb + 2) >>> 2;
    if (s0 || s1) begin hi = 511;  lo = -512; end
    else          begin hi = 1023; lo = 0;    end
    o = (r > hi) || (r < lo);
    c = (r > hi) ? hi : (r < lo) ? lo : r;
    d = c[9:0];
  endfunction

  int p4_ce_t [15] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  int p4_v_t  [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int p4_a_t  [15] = '{1, 2, 99, 99, 99, 3, 4, 5, 6, 77, 77, 0, 0, 0, 0};
  int p4_ev_t [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int p4_ed_t [15] = '{0, 0, 0, 0, 0, 0, 3, 6, 9, 9, 9, 12, 15, 18, 0};

  logic [7:0] h_a [NT];
  logic [5:0] h_b [NT];
  logic       h_v [NT];
  int         obs_cnt [NSW];
  int         exp_cnt;

  initial begin
    rst_n  = 1'b0;  p3_rst = 1'b0;
    def_ce = 1'b1;  def_v = 1'b1;  def_a = 32'd5;  def_b = 15'd5;
    sh_ce  = 1'b1;  sh_v  = 1'b0;  sh_a  = '0;     sh_b  = '0;
    s_ce   = 1'b1;  s_v   = 1'b0;  s_a   = '0;     s_b   = '0;
    p4_ce  = 1'b0;  p4_v  = 1'b0;  p4_a  = '0;     p4_b  = 15'd3;
    p3_ce  = 1'b1;  p3_v  = 1'b0;  p3_a  = '0;     p3_b  = '0;
    sw_v   = 1'b0;  sw_a  = '0;    sw_b  = '0;
    for (int i = 0; i < NSW; i++) obs_cnt[i] = 0;

    // ---- reset state: in_valid during reset is discarded ----
    tick(); tick();
    chk("rst_valid", def_ov, 0);
    chk("rst_dout",  def_d,  0);
    chk("rst_ovf",   def_o,  0);
    rst_n = 1'b1; p3_rst = 1'b1; def_v = 1'b0;
    tick(); tick();
    chk("rst_no_ghost", def_ov, 0);

    // ---- 1: defaults, -3 * 32767 ----
    def_v = 1'b1; def_a = 32'hFFFF_FFFD; def_b = 15'h7FFF;
    tick();
    def_v = 1'b0;
    chk("def_lat1_valid", def_ov, 0);
    tick();
    chk("def_valid", def_ov, 1);
    chk("def_dout",  def_d,  46'h3FFF_FFFE_8003);
    chk("def_ovf",   def_o,  0);
    tick();
    chk("def_bubble", def_ov, 0);

    // ---- 2: SHIFT=4 rounding, back to back ----
    sh_v = 1'b1; sh_a = 32'd6; sh_b = 15'd4;                 // 24
    tick();
    sh_a = 32'hFFFF_FFFA;                                    // -24
    tick();
    chk("sh24_valid", sh_ov, 1);
    chk("sh24_dout",  sh_d,  46'd2);
    sh_a = 32'd2;                                            // 8, half rounds up
    tick();
    sh_v = 1'b0;
    chk("shm24_dout", sh_d, 46'h3FFF_FFFF_FFFF);
    chk("shm24_ovf",  sh_o, 0);
    tick();
    chk("sh8_valid", sh_ov, 1);
    chk("sh8_dout",  sh_d,  46'd1);
    tick();
    chk("sh_drain", sh_ov, 0);

    // ---- 3: 16-bit output, saturate vs wrap ----
    s_v = 1'b1; s_a = 32'd1000; s_b = 15'd1000;
    tick();
    s_a = 32'hFFFF_FC18;                                     // -1000
    tick();
    chk("sat_pos_dout", sat_d, 16'h7FFF);
    chk("sat_pos_ovf",  sat_o, 1);
    chk("wrp_pos_dout", wrp_d, 16'h4240);
    chk("wrp_pos_ovf",  wrp_o, 1);
    s_a = 32'd100; s_b = 15'h7FFD;                           // 100 * -3
    tick();
    s_v = 1'b0;
    chk("sat_neg_dout", sat_d, 16'h8000);
    chk("sat_neg_ovf",  sat_o, 1);
    chk("wrp_neg_dout", wrp_d, 16'hBDC0);
    chk("wrp_neg_ovf",  wrp_o, 1);
    tick();
    chk("sat_fit_valid", sat_ov, 1);
    chk("sat_fit_dout",  sat_d,  16'hFED4);
    chk("sat_fit_ovf",   sat_o,  0);
    chk("wrp_fit_dout",  wrp_d,  16'hFED4);

    // ---- 4: NUM_STAGE=4 stream with stalls ----
    for (int e = 0; e < 15; e++) begin
      p4_ce = (p4_ce_t[e] != 0);
      p4_v  = (p4_v_t[e] != 0);
      p4_a  = p4_a_t[e];
      tick();
      chk($sformatf("p4_valid_e%0d", e + 1), p4_ov, p4_ev_t[e]);
      if (p4_ev_t[e] != 0) begin
        chk($sformatf("p4_dout_e%0d", e + 1), p4_d, p4_ed_t[e]);
        chk($sformatf("p4_ovf_e%0d", e + 1),  p4_o, 0);
      end
    end

    // ---- 5: NUM_STAGE=3 reset flush ----
    p3_v = 1'b1; p3_a = 32'd5; p3_b = 15'd7;
    tick();
    p3_v = 1'b0; p3_rst = 1'b0;
    tick();
    chk("p3_rst_valid", p3_ov, 0);
    chk("p3_rst_dout",  p3_d,  0);
    chk("p3_rst_ovf",   p3_o,  0);
    p3_rst = 1'b1; p3_v = 1'b1; p3_a = 32'd9; p3_b = 15'd4;
    tick();
    p3_v = 1'b0;
    chk("p3_flush1", p3_ov, 0);
    tick();
    chk("p3_flush2", p3_ov, 0);
    tick();
    chk("p3_op_valid", p3_ov, 1);
    chk("p3_op_dout",  p3_d,  46'd36);
    tick();
    chk("p3_op_drain", p3_ov, 0);

    // ---- 6: sweep ----
    exp_cnt = 0;
    for (int t = 0; t < NT; t++) begin
      if (t == 0)      begin h_a[t] = 8'h80; h_b[t] = 6'h20; h_v[t] = 1'b1; end
      else if (t == 1) begin h_a[t] = 8'h7F; h_b[t] = 6'h3F; h_v[t] = 1'b1; end
      else if (t == 2) begin h_a[t] = 8'hFF; h_b[t] = 6'h1F; h_v[t] = 1'b1; end
      else if (t == 3) begin h_a[t] = 8'h06; h_b[t] = 6'h01; h_v[t] = 1'b1; end
      else if (t < 40) begin
        h_a[t] = 8'($urandom);
        h_b[t] = 6'($urandom);
        h_v[t] = ($urandom_range(3) != 0);
      end else begin
        h_a[t] = 8'($urandom); h_b[t] = 6'($urandom); h_v[t] = 1'b0;
      end
      if (h_v[t]) exp_cnt++;
    end

    for (int t = 0; t < NT; t++) begin
      sw_a = h_a[t]; sw_b = h_b[t]; sw_v = h_v[t];
      tick();
      for (int i = 0; i < NSW; i++) begin
        int         ns;
        int         j;
        logic       ev;
        logic [9:0] ed;
        logic       eo;
        ns = (i < 4) ? 1 : (i < 8) ? 2 : 8;
        j  = t - ns + 1;
        ev = (j >= 0) ? h_v[j] : 1'b0;
        if (sw_ov[i] === 1'b1) obs_cnt[i]++;
        chk($sformatf("sw%0d_valid_t%0d", i, t), sw_ov[i], ev);
        if (ev) begin
          model(i, h_a[j], h_b[j], ed, eo);
          chk($sformatf("sw%0d_dout_t%0d", i, t), sw_d[i], ed);
          chk($sformatf("sw%0d_ovf_t%0d", i, t),  sw_o[i], eo);
        end
      end
    end
    for (int i = 0; i < NSW; i++) begin
      chk($sformatf("sw%0d_count", i), obs_cnt[i], exp_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_adpcm_main_mul_pipe_sat
`default_nettype wire
